// File: rtl/cpu_m.sv
// Single-cycle 8-bit register-machine core: four general registers plus zero/sign
// flags, executing one externally supplied 20-bit instruction per rising clock edge.

package cpu_m_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_MOV  = 4'h1,
        OP_LDI  = 4'h2,
        OP_ADD  = 4'h3,
        OP_SUB  = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_XOR  = 4'h7,
        OP_NOT  = 4'h8,
        OP_SHL  = 4'h9,
        OP_SHR  = 4'hA,
        OP_ADDI = 4'hB,
        OP_SUBI = 4'hC,
        OP_CMP  = 4'hD,
        OP_INC  = 4'hE,
        OP_DEC  = 4'hF
    } opcode_t;

    typedef struct packed {
        opcode_t    op;
        logic [1:0] dst;
        logic [1:0] src;
        logic [3:0] rsvd;
        logic [7:0] imm;
    } instr_t;

    // Everything past the three pure data moves updates the flags.
    function automatic logic writes_flags(input opcode_t op);
        return !(op inside {OP_NOP, OP_MOV, OP_LDI});
    endfunction

    function automatic logic writes_reg(input opcode_t op);
        return !(op inside {OP_NOP, OP_CMP});
    endfunction

endpackage

module cpu_m
    import cpu_m_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] ins,
    output logic [7:0]  ra,
    output logic [7:0]  rb,
    output logic [7:0]  rc,
    output logic [7:0]  rd,
    output logic        zf,
    output logic        sf
);

    instr_t     instr;
    logic       unused_rsvd;

    logic [7:0] regs_q [4];
    logic [7:0] regs_d [4];
    logic       zf_q, zf_d;
    logic       sf_q, sf_d;

    logic [7:0] d_val;
    logic [7:0] s_val;
    logic [7:0] res;

    assign instr       = instr_t'(ins);
    assign unused_rsvd = ^instr.rsvd;

    // Both operands come from the current register state, so D==S reads the old value.
    assign d_val = regs_q[instr.dst];
    assign s_val = regs_q[instr.src];

    // NOTE: every variable gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        res = 8'h00;
        unique case (instr.op)
            OP_NOP:  res = d_val;
            OP_MOV:  res = s_val;
            OP_LDI:  res = instr.imm;
            OP_ADD:  res = d_val + s_val;
            OP_SUB:  res = d_val - s_val;
            OP_AND:  res = d_val & s_val;
            OP_OR:   res = d_val | s_val;
            OP_XOR:  res = d_val ^ s_val;
            OP_NOT:  res = ~s_val;
            OP_SHL:  res = {s_val[6:0], 1'b0};
            OP_SHR:  res = {1'b0, s_val[7:1]};
            OP_ADDI: res = d_val + instr.imm;
            OP_SUBI: res = d_val - instr.imm;
            OP_CMP:  res = d_val - s_val;
            OP_INC:  res = d_val + 8'd1;
            OP_DEC:  res = d_val - 8'd1;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        zf_d   = zf_q;
        sf_d   = sf_q;
        if (writes_reg(instr.op)) begin
            regs_d[instr.dst] = res;
        end
        if (writes_flags(instr.op)) begin
            zf_d = (res == 8'h00);
            sf_d = res[7];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values. The register file is only four entries and is fully
    // architectural state, so each entry is reset rather than left undefined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= 8'h00;
            end
            zf_q <= 1'b0;
            sf_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            zf_q   <= zf_d;
            sf_q   <= sf_d;
        end
    end

    assign ra = regs_q[0];
    assign rb = regs_q[1];
    assign rc = regs_q[2];
    assign rd = regs_q[3];
    assign zf = zf_q;
    assign sf = sf_q;

endmodule

// File: tb/tb_cpu_m.sv
// Self-checking bench for cpu_m: directed instruction sequences with literal
// expectations, a random instruction stream, and a per-cycle compare against a model.

module tb_cpu_m;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [19:0] ins_i = 20'h0;
    logic [7:0]  ra, rb, rc, rd;
    logic        zf, sf;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    int m_reg [4];
    bit m_zf;
    bit m_sf;

    cpu_m dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ins   (ins_i),
        .ra    (ra),
        .rb    (rb),
        .rc    (rc),
        .rd    (rd),
        .zf    (zf),
        .sf    (sf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] mk(input logic [3:0] op, input logic [1:0] d,
                                       input logic [1:0] s, input logic [7:0] imm);
        return {op, d, s, 4'h0, imm};
    endfunction

    // Reference: integer arithmetic reduced modulo 256.
    function automatic void model_exec(input logic [19:0] x);
        int op  = int'(x[19:16]);
        int dn  = int'(x[15:14]);
        int sn  = int'(x[13:12]);
        int imm = int'(x[7:0]);
        int d   = m_reg[dn];
        int s   = m_reg[sn];
        int r   = 0;
        bit wr  = 1'b1;
        bit fl  = 1'b1;
        case (op)
            0:  begin wr = 1'b0; fl = 1'b0; end
            1:  begin r = s;   fl = 1'b0; end
            2:  begin r = imm; fl = 1'b0; end
            3:  r = d + s;
            4:  r = d - s;
            5:  r = d & s;
            6:  r = d | s;
            7:  r = d ^ s;
            8:  r = 255 - s;
            9:  r = s * 2;
            10: r = s / 2;
            11: r = d + imm;
            12: r = d - imm;
            13: begin r = d - s; wr = 1'b0; end
            14: r = d + 1;
            default: r = d - 1;
        endcase
        r = (r + 512) % 256;
        if (wr) m_reg[dn] = r;
        if (fl) begin
            m_zf = (r == 0);
            m_sf = (r >= 128);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_reg[i] = 0;
            m_zf = 1'b0;
            m_sf = 1'b0;
        end else begin
            model_exec(ins_i);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_ra", ra, 8'(m_reg[0]));
            check("cyc_rb", rb, 8'(m_reg[1]));
            check("cyc_rc", rc, 8'(m_reg[2]));
            check("cyc_rd", rd, 8'(m_reg[3]));
            check("cyc_zf", {7'b0, zf}, {7'b0, m_zf});
            check("cyc_sf", {7'b0, sf}, {7'b0, m_sf});
        end
    end

    task automatic run(input logic [19:0] x);
        ins_i = x;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ra"}, ra, 8'h00);
        check({tag, "_rb"}, rb, 8'h00);
        check({tag, "_rc"}, rc, 8'h00);
        check({tag, "_rd"}, rd, 8'h00);
        check({tag, "_zf"}, {7'b0, zf}, 8'h00);
        check({tag, "_sf"}, {7'b0, sf}, 8'h00);
    endtask

    initial begin
        logic [31:0] rnd;

        // Reset and idle NOPs
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst");
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        repeat (5) run(20'h0);
        check_all_zero("nop");

        // Add into sign bit
        run(mk(4'h2, 2'd0, 2'd0, 8'h7F));
        run(mk(4'h2, 2'd1, 2'd0, 8'h01));
        run(mk(4'h3, 2'd0, 2'd1, 8'h00));
        check("add_ra", ra, 8'h80);
        check("add_rb", rb, 8'h01);
        check("add_sf", {7'b0, sf}, 8'h01);
        check("add_zf", {7'b0, zf}, 8'h00);

        // Wrap on INC/DEC
        run(mk(4'h2, 2'd2, 2'd0, 8'hFF));
        run(mk(4'hE, 2'd2, 2'd0, 8'h00));
        check("inc_rc", rc, 8'h00);
        check("inc_zf", {7'b0, zf}, 8'h01);
        check("inc_sf", {7'b0, sf}, 8'h00);
        run(mk(4'hF, 2'd2, 2'd0, 8'h00));
        check("dec_rc", rc, 8'hFF);
        check("dec_zf", {7'b0, zf}, 8'h00);
        check("dec_sf", {7'b0, sf}, 8'h01);

        // CMP sets flags only; LDI keeps flags
        run(mk(4'h2, 2'd3, 2'd0, 8'h05));
        run(mk(4'h2, 2'd0, 2'd0, 8'h05));
        run(mk(4'hD, 2'd3, 2'd0, 8'h00));
        check("cmp_rd", rd, 8'h05);
        check("cmp_zf", {7'b0, zf}, 8'h01);
        run(mk(4'h2, 2'd0, 2'd0, 8'h09));
        check("ldi_ra", ra, 8'h09);
        check("ldi_keep_zf", {7'b0, zf}, 8'h01);

        // Same-register operands, logic and shifts
        run(mk(4'h3, 2'd0, 2'd0, 8'h00));
        check("dbl_ra", ra, 8'h12);
        run(mk(4'h2, 2'd1, 2'd0, 8'hA5));
        run(mk(4'h7, 2'd1, 2'd1, 8'h00));
        check("xor_rb", rb, 8'h00);
        check("xor_zf", {7'b0, zf}, 8'h01);
        run(mk(4'h2, 2'd1, 2'd0, 8'h81));
        run(mk(4'hA, 2'd2, 2'd1, 8'h00));
        check("shr_rc", rc, 8'h40);
        run(mk(4'h9, 2'd2, 2'd1, 8'h00));
        check("shl_rc", rc, 8'h02);
        check("shl_rb", rb, 8'h81);

        // Random stream, ignored field included
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom;
            run(rnd[19:0]);
        end

        // Asynchronous reset between edges
        run(mk(4'h2, 2'd3, 2'd0, 8'hC3));
        run(mk(4'hF, 2'd3, 2'd0, 8'h00));
        #2 rst_n = 1'b0;
        #1 check_all_zero("arst");
        @(negedge clk);
        rst_n = 1'b1;
        ins_i = 20'h0;
        run(mk(4'h2, 2'd0, 2'd0, 8'h3C));
        check("post_ra", ra, 8'h3C);
        check("post_zf", {7'b0, zf}, 8'h00);
        repeat (2) @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
